// File: rtl/dfm_pkg.sv
// dfm_pkg: shared types and constants for dataflow_perf_monitor.
//   dfm_state_t  per-channel handshake FSM state (encoding is visible in STATUS)
//   REG_*        readout register indices for rd_reg
//   STAT_*       STATUS register field positions
//   sat_inc      saturating increment for any counter width up to SAT_MAX_W
package dfm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_DONE_WAIT = 2'd2
  } dfm_state_t;

  localparam logic [2:0] REG_TXN      = 3'd0;
  localparam logic [2:0] REG_BUSY     = 3'd1;
  localparam logic [2:0] REG_BLOCK    = 3'd2;
  localparam logic [2:0] REG_LAST_LAT = 3'd3;
  localparam logic [2:0] REG_MAX_LAT  = 3'd4;
  localparam logic [2:0] REG_ITER     = 3'd5;
  localparam logic [2:0] REG_STATUS   = 3'd6;

  // One sticky overflow flag per counter register 0..5.
  localparam int unsigned NUM_CNT = 6;

  localparam int unsigned STAT_STATE_LSB = 0;
  localparam int unsigned STAT_STATE_W   = 2;
  localparam int unsigned STAT_OVF_LSB   = 2;

  localparam int unsigned SAT_MAX_W = 48;

  // Increment v, holding at 2^w-1. Callers zero-extend into SAT_MAX_W bits
  // and truncate the result back to their own width.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                   input int unsigned        w);
    logic [SAT_MAX_W-1:0] top;
    top = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
    return (v >= top) ? top : v + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/dfm_channel.sv
// dfm_channel: one monitored ap_ctrl_hs handshake.
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   enable, clear       counter update enable / synchronous counter+flag clear
//   ap_start, ap_done,
//   ap_continue         handshake observed on this channel
//   iter_valid          pre-qualified loop-iteration strobe
//   state, busy         FSM state and registered activity flag
//   txn .. iter_cnt     saturating counters (registers 0..5)
//   ovf                 sticky overflow flags, bit i belongs to register i
module dfm_channel
  import dfm_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               ap_start,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic               iter_valid,
  output dfm_state_t         state,
  output logic               busy,
  output logic [CNT_W-1:0]   txn,
  output logic [CNT_W-1:0]   busy_cnt,
  output logic [CNT_W-1:0]   block_cnt,
  output logic [CNT_W-1:0]   last_lat,
  output logic [CNT_W-1:0]   max_lat,
  output logic [CNT_W-1:0]   iter_cnt,
  output logic [NUM_CNT-1:0] ovf
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(SAT_MAX_W'(v), CNT_W));
  endfunction

  dfm_state_t         state_nxt;
  logic [CNT_W-1:0]   lat;
  logic [CNT_W-1:0]   lat_nxt;
  logic               complete;
  logic [CNT_W-1:0]   comp_lat;
  logic               comp_sat;
  logic               busy_inc;
  logic               block_inc;
  logic [NUM_CNT-1:0] ovf_set;

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat;
    complete  = 1'b0;
    comp_lat  = '0;
    comp_sat  = 1'b0;
    busy_inc  = 1'b0;
    block_inc = 1'b0;
    if (state == ST_RUN) begin
      busy_inc = 1'b1;
      lat_nxt  = inc(lat);
      if (ap_done) begin
        complete  = 1'b1;
        comp_lat  = inc(lat);
        comp_sat  = (lat == '1);
        state_nxt = ap_continue ? ST_IDLE : ST_DONE_WAIT;
      end
    end else if (state == ST_IDLE || ap_continue) begin
      // IDLE, or DONE_WAIT being released this cycle: both can launch a new
      // transaction, including a same-cycle start/done of latency 1.
      state_nxt = ST_IDLE;
      if (ap_start) begin
        busy_inc = 1'b1;
        lat_nxt  = ONE;
        if (ap_done) begin
          complete  = 1'b1;
          comp_lat  = ONE;
          state_nxt = ap_continue ? ST_IDLE : ST_DONE_WAIT;
        end else begin
          state_nxt = ST_RUN;
        end
      end
    end else begin
      block_inc = 1'b1;
    end
  end

  always_comb begin
    ovf_set               = '0;
    ovf_set[REG_TXN]      = complete && (txn == '1);
    ovf_set[REG_BUSY]     = busy_inc && (busy_cnt == '1);
    ovf_set[REG_BLOCK]    = block_inc && (block_cnt == '1);
    ovf_set[REG_LAST_LAT] = complete && comp_sat;
    ovf_set[REG_MAX_LAT]  = complete && comp_sat;
    ovf_set[REG_ITER]     = iter_valid && (iter_cnt == '1);
  end

  // busy covers every cycle a transaction occupies (including the start
  // cycle seen in IDLE), presented one cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      lat   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      lat   <= lat_nxt;
      busy  <= (state != ST_IDLE) || ap_start;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txn       <= '0;
      busy_cnt  <= '0;
      block_cnt <= '0;
      last_lat  <= '0;
      max_lat   <= '0;
      iter_cnt  <= '0;
      ovf       <= '0;
    end else if (clear) begin
      txn       <= '0;
      busy_cnt  <= '0;
      block_cnt <= '0;
      last_lat  <= '0;
      max_lat   <= '0;
      iter_cnt  <= '0;
      ovf       <= '0;
    end else if (enable) begin
      if (complete) begin
        txn      <= inc(txn);
        last_lat <= comp_lat;
        if (comp_lat > max_lat) max_lat <= comp_lat;
      end
      if (busy_inc)   busy_cnt  <= inc(busy_cnt);
      if (block_inc)  block_cnt <= inc(block_cnt);
      if (iter_valid) iter_cnt  <= inc(iter_cnt);
      ovf <= ovf | ovf_set;
    end
  end

endmodule

// File: rtl/dataflow_perf_monitor.sv
// dataflow_perf_monitor: multi-channel ap_ctrl_hs performance counters.
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   enable                1 = counters update, 0 = counters frozen
//   clear                 zero all counters and overflow flags
//   ap_start/ready/done/continue, iter_valid   per-channel observed signals
//   rd_ch, rd_reg         readout select (channel, register)
//   rd_data               selected value, registered, 1-cycle latency
//   busy                  per-channel activity flag
module dataflow_perf_monitor
  import dfm_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned CNT_W  = 32,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [NUM_CH-1:0] iter_valid,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_reg,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] busy
);

  dfm_state_t         state     [NUM_CH];
  logic [CNT_W-1:0]   txn       [NUM_CH];
  logic [CNT_W-1:0]   busy_cnt  [NUM_CH];
  logic [CNT_W-1:0]   block_cnt [NUM_CH];
  logic [CNT_W-1:0]   last_lat  [NUM_CH];
  logic [CNT_W-1:0]   max_lat   [NUM_CH];
  logic [CNT_W-1:0]   iter_cnt  [NUM_CH];
  logic [NUM_CNT-1:0] ovf       [NUM_CH];
  logic [CNT_W-1:0]   sel;

  // Start acceptance is implied by the FSM state, so ap_ready carries no
  // extra information; it stays on the port list for handshake wiring.
  logic unused_ready;
  always_comb unused_ready = ^ap_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dfm_channel #(.CNT_W(CNT_W)) u_ch (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .clear       (clear),
      .ap_start    (ap_start[g]),
      .ap_done     (ap_done[g]),
      .ap_continue (ap_continue[g]),
      .iter_valid  (iter_valid[g]),
      .state       (state[g]),
      .busy        (busy[g]),
      .txn         (txn[g]),
      .busy_cnt    (busy_cnt[g]),
      .block_cnt   (block_cnt[g]),
      .last_lat    (last_lat[g]),
      .max_lat     (max_lat[g]),
      .iter_cnt    (iter_cnt[g]),
      .ovf         (ovf[g])
    );
  end

  always_comb begin
    sel = '0;
    if (32'(rd_ch) < NUM_CH) begin
      case (rd_reg)
        REG_TXN:      sel = txn[rd_ch];
        REG_BUSY:     sel = busy_cnt[rd_ch];
        REG_BLOCK:    sel = block_cnt[rd_ch];
        REG_LAST_LAT: sel = last_lat[rd_ch];
        REG_MAX_LAT:  sel = max_lat[rd_ch];
        REG_ITER:     sel = iter_cnt[rd_ch];
        REG_STATUS: begin
          sel[STAT_STATE_LSB +: STAT_STATE_W] = state[rd_ch];
          sel[STAT_OVF_LSB +: NUM_CNT]        = ovf[rd_ch];
        end
        default:      sel = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= sel;
  end

endmodule

// File: doc/dataflow_perf_monitor.md
# dataflow_perf_monitor

Synthesizable, multi-channel successor to the simulation-only dataflow monitor. It observes up to NUM_CH `ap_ctrl_hs`-style module handshakes plus one loop-iteration strobe per channel. Per channel it keeps saturating counters for transactions, busy cycles, done/continue back-pressure, last and maximum latency, and loop iterations. Counters are read through a registered select/readout port, so a kernel's dataflow behaviour can be profiled on silicon.

## Interface
- NUM_CH, 4, number of monitored channels (1..16)
- CNT_W, 32, counter width (8..48)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = counters update; 0 = counters frozen, FSMs keep tracking
- clear  in  1  single-cycle pulse that zeroes all counters and overflow flags
- ap_start  in  NUM_CH  per-channel start
- ap_ready  in  NUM_CH  per-channel ready
- ap_done  in  NUM_CH  per-channel done
- ap_continue  in  NUM_CH  per-channel continue; tie to 1 if unused
- iter_valid  in  NUM_CH  one pulse per completed loop iteration, pre-qualified by the wrapper (end-stage enable & !block)
- rd_ch  in  $clog2(NUM_CH) (min 1)  channel select
- rd_reg  in  3  register select
- rd_data  out  CNT_W  selected value, registered
- busy  out  NUM_CH  per-channel FSM is not IDLE

## Operation
- Per-channel FSM, states IDLE, RUN, DONE_WAIT:
  - IDLE→RUN on ap_start=1. Latency accumulator lat := 1.
  - In IDLE, ap_start & ap_done in the same cycle: the transaction completes with latency 1. Next state is IDLE if ap_continue=1, else DONE_WAIT.
  - RUN: lat += 1 each cycle. On ap_done=1, the transaction completes with latency lat+1. Next state is IDLE if ap_continue=1, else DONE_WAIT.
  - DONE_WAIT→IDLE on ap_continue=1. ap_start in that same cycle goes directly to RUN with lat := 1.
- On transaction completion (counted in the ap_done cycle):
  - TXN += 1
  - LAST_LAT := latency
  - MAX_LAT := max(MAX_LAT, latency)
- Other counters:
  - BUSY += 1 on every cycle in RUN, and on the completion cycle.
  - BLOCK += 1 on every cycle in DONE_WAIT with ap_continue=0.
  - ITER += 1 per iter_valid cycle, in any state.
- Register map (rd_reg): 0 TXN, 1 BUSY, 2 BLOCK, 3 LAST_LAT, 4 MAX_LAT, 5 ITER, 6 STATUS, 7 reads 0.
  - STATUS: bits[1:0] FSM state (0 IDLE, 1 RUN, 2 DONE_WAIT); bits[7:2] sticky overflow flags for regs 0..5; remaining bits 0.
- Width rules:
  - All counters saturate at 2^CNT_W−1 and never wrap. The first increment attempted at saturation sets the matching sticky overflow flag.
  - lat saturates the same way. LAST_LAT/MAX_LAT then record all-ones.
- enable=0 blocks all counter and register updates, but the FSM and lat still advance. A transaction completing while enable=0 is not counted.
- clear:
  - Zeroes TXN, BUSY, BLOCK, LAST_LAT, MAX_LAT, ITER and the overflow flags.
  - Does not alter FSM state or lat, so an in-flight transaction completes with its true latency.
  - clear wins over any same-cycle increment.
- rd_ch ≥ NUM_CH reads 0.

## Timing
- Reset: all FSMs IDLE; all counters, lat and flags 0; rd_data=0; busy=0.
- Reset assertion mid-transaction aborts it immediately, with no partial count.
- busy is registered: it reflects the FSM state, 1 cycle after the triggering edge.
- rd_data latency is 1 cycle. The value reflects counter contents before the updates of the select cycle.
  - Reading in the same cycle as clear returns the pre-clear value.
  - The next read returns 0 (or 1 if an event coincided after clear).
- Inputs are sampled on clock; no combinational path from inputs to outputs.

## Structure
- Package dfm_pkg holds:
  - the state enum (IDLE/RUN/DONE_WAIT)
  - register index constants REG_TXN..REG_STATUS
  - STATUS bit positions
  - a saturating-increment function parameterised on width
- Sub-module dfm_channel (one FSM, lat, six counters, flags), instantiated NUM_CH times by generate.
- Top level holds only the readout mux and rd_data register.

## Test plan
- Single run: start at cycle 0, done at cycle 9, continue=1 → TXN=1, LAST_LAT=10, MAX_LAT=10, BUSY=10, BLOCK=0, busy high for cycles 1..10.
- Back-pressure: done at cycle 4 with continue low for 3 cycles → BLOCK=3, STATUS state=2 during the wait, then IDLE.
- Zero-latency: start & done in the same cycle, three times back-to-back → TXN=3, LAST_LAT=1, MAX_LAT=1.
- Saturation with CNT_W=8: 300 iter_valid pulses → ITER=255, STATUS bit 7 set. A subsequent clear → ITER=0, bit 7 cleared.
- Clear mid-run: start at cycle 0, clear at cycle 5, done at cycle 9 → TXN=1, LAST_LAT=10, BUSY=4. A read with clear in the same cycle returns the old BUSY.
- Multi-channel, NUM_CH=4: distinct latencies 3/5/7/9 and enable=0 during channel 2's done → per-channel LAST_LAT 3/5/0/9. rd_ch=4 (with NUM_CH=4 tied to a wider select) reads 0. Async reset mid-run zeroes everything.
